// File: rtl/sc_speedtimer_backg.sv
// Background-lane speed timer: counts enabled cycles up to a latched limit, then
// issues a one-cycle active-low T0 tick for the background level state machine.
module sc_speedtimer_backg #(
  parameter int unsigned SPEEDTIMER_DATAWIDTH = 25,
  parameter bit          SPEEDTIMER_RELOAD    = 1'b0
) (
  input  logic                            SC_SPEEDTIMER_CLOCK_50,
  input  logic                            SC_SPEEDTIMER_RESET_InLow,
  input  logic                            SC_SPEEDTIMER_clear_InLow,
  input  logic                            SC_SPEEDTIMER_upcount_InLow,
  input  logic [SPEEDTIMER_DATAWIDTH-1:0] SC_SPEEDTIMER_limit_InBus,
  output logic                            SC_SPEEDTIMER_T0_OutLow,
  output logic [SPEEDTIMER_DATAWIDTH-1:0] SC_SPEEDTIMER_count_OutBus,
  output logic                            SC_SPEEDTIMER_busy_Out,
  output logic [7:0]                      SC_SPEEDTIMER_tickcount_OutBus
);

  localparam int unsigned DW = SPEEDTIMER_DATAWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TICK = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [DW-1:0]   count, count_next;
  logic [DW-1:0]   limit_reg, limit_next;
  logic [7:0]      tickcount, tickcount_next;

  // NOTE: every target gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred; blocking '=' is correct in always_comb.
  always_comb begin
    state_next     = state;
    count_next     = count;
    limit_next     = limit_reg;
    tickcount_next = tickcount;

    if (!SC_SPEEDTIMER_clear_InLow) begin
      state_next     = ST_IDLE;
      count_next     = '0;
      tickcount_next = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          count_next = '0;
          if (!SC_SPEEDTIMER_upcount_InLow) begin
            state_next = ST_RUN;
            limit_next = SC_SPEEDTIMER_limit_InBus;
          end
        end

        ST_RUN: begin
          if (SC_SPEEDTIMER_upcount_InLow) begin
            state_next = ST_IDLE;
            count_next = '0;
          end else if (count == limit_reg) begin
            state_next = ST_TICK;
            count_next = '0;
          end else begin
            count_next = count + DW'(1);
          end
        end

        ST_TICK: begin
          count_next     = '0;
          tickcount_next = tickcount + 8'd1;
          if (SPEEDTIMER_RELOAD == 1'b0) begin
            state_next = ST_WAIT;
          end else if (!SC_SPEEDTIMER_upcount_InLow) begin
            state_next = ST_RUN;
            limit_next = SC_SPEEDTIMER_limit_InBus;
          end else begin
            state_next = ST_IDLE;
          end
        end

        ST_WAIT: begin
          // Holds here until the enable drops, so one episode yields one tick.
          count_next = '0;
          if (SC_SPEEDTIMER_upcount_InLow) begin
            state_next = ST_IDLE;
          end
        end

        default: begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge SC_SPEEDTIMER_CLOCK_50 or negedge SC_SPEEDTIMER_RESET_InLow) begin
    if (!SC_SPEEDTIMER_RESET_InLow) begin
      state     <= ST_IDLE;
      count     <= '0;
      limit_reg <= '0;
      tickcount <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      limit_reg <= limit_next;
      tickcount <= tickcount_next;
    end
  end

  // Flags decode the state register only, so reset forces T0 high immediately.
  assign SC_SPEEDTIMER_T0_OutLow        = (state != ST_TICK);
  assign SC_SPEEDTIMER_busy_Out         = (state == ST_RUN);
  assign SC_SPEEDTIMER_count_OutBus     = count;
  assign SC_SPEEDTIMER_tickcount_OutBus = tickcount;

endmodule
